// File: rtl/time_pkg.sv
// Shared types and limits for the time-entry block: field and FSM encodings,
// BCD digit width and the committed-value range limits.
package time_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned PAIR_BIN_W = 7;  // 99 is the largest two-digit value
  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned MINSEC_MAX = 59;

  typedef enum logic [1:0] {
    FieldNone = 2'd0,
    FieldHour = 2'd1,
    FieldMin  = 2'd2,
    FieldSec  = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEntry  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // The sequencer may leave earlier enables high, so the latest field wins.
  function automatic field_e field_select(input logic hour_en,
                                          input logic min_en,
                                          input logic sec_en);
    field_e f;
    if (sec_en) begin
      f = FieldSec;
    end else if (min_en) begin
      f = FieldMin;
    end else if (hour_en) begin
      f = FieldHour;
    end else begin
      f = FieldNone;
    end
    return f;
  endfunction

endpackage

// File: rtl/bcd_pair_reg.sv
// Two-digit BCD staging register: synchronous clear, shift-in of a new units
// digit, and a binary view of the staged value.
module bcd_pair_reg
  import time_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [BCD_W-1:0]      digit_i,
  output logic [PAIR_BIN_W-1:0] bin_o
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;

  // Clear is applied before the shift so a digit arriving with the clear
  // lands in an otherwise empty pair.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end
    if (shift_i) begin
      tens_d  = units_d;
      units_d = digit_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  always_comb begin
    bin_o = PAIR_BIN_W'(tens_q) * PAIR_BIN_W'(10) + PAIR_BIN_W'(units_q);
  end

endmodule

// File: rtl/time_entry.sv
// Keypad time entry: stages hour/minute/second digits per selected field and
// commits them as binary values on the rising edge of completeSetting.
module time_entry
  import time_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             hour_en,
  input  logic             min_en,
  input  logic             sec_en,
  input  logic             completeSetting,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  output logic [4:0]       hour_out,
  output logic [5:0]       min_out,
  output logic [5:0]       sec_out,
  output logic             load,
  output logic             entry_error,
  output logic [1:0]       cur_field
);

  field_e field_q, field_d;
  state_e state_q, state_d;
  logic   cs_q;
  logic   err_q, err_d;

  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;

  logic [PAIR_BIN_W-1:0] hour_bin, min_bin, sec_bin;

  logic field_entry, key_ok, cs_rise, in_commit, range_ok, commit_ok;
  logic clr_hour, clr_min, clr_sec;
  logic shift_hour, shift_min, shift_sec;

  // Keys are routed by the field being selected this cycle, so a digit that
  // arrives together with a field change goes into the new field.
  always_comb begin
    field_d     = field_select(hour_en, min_en, sec_en);
    field_entry = (field_d != FieldNone) && (field_d != field_q);
    key_ok      = key_valid && (key_digit <= 4'd9) && (field_d != FieldNone);
    clr_hour    = field_entry && (field_d == FieldHour);
    clr_min     = field_entry && (field_d == FieldMin);
    clr_sec     = field_entry && (field_d == FieldSec);
    shift_hour  = key_ok && (field_d == FieldHour);
    shift_min   = key_ok && (field_d == FieldMin);
    shift_sec   = key_ok && (field_d == FieldSec);
  end

  bcd_pair_reg u_hour_pair (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (clr_hour),
    .shift_i (shift_hour),
    .digit_i (key_digit),
    .bin_o   (hour_bin)
  );

  bcd_pair_reg u_min_pair (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (clr_min),
    .shift_i (shift_min),
    .digit_i (key_digit),
    .bin_o   (min_bin)
  );

  bcd_pair_reg u_sec_pair (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (clr_sec),
    .shift_i (shift_sec),
    .digit_i (key_digit),
    .bin_o   (sec_bin)
  );

  always_comb begin
    cs_rise = completeSetting && !cs_q;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cs_rise) begin
          state_d = StCommit;
        end else if (hour_en || min_en || sec_en) begin
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (cs_rise) begin
          state_d = StCommit;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Commit results are visible combinationally during the COMMIT cycle and
  // held in the output registers afterwards.
  always_comb begin
    in_commit = (state_q == StCommit);
    range_ok  = (hour_bin <= PAIR_BIN_W'(HOUR_MAX)) &&
                (min_bin  <= PAIR_BIN_W'(MINSEC_MAX)) &&
                (sec_bin  <= PAIR_BIN_W'(MINSEC_MAX));
    commit_ok = in_commit && range_ok;

    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (commit_ok) begin
      hour_d = hour_bin[4:0];
      min_d  = min_bin[5:0];
      sec_d  = sec_bin[5:0];
    end

    err_d = err_q;
    if (in_commit) begin
      err_d = !range_ok;
    end else if (field_entry) begin
      err_d = 1'b0;
    end

    hour_out    = hour_d;
    min_out     = min_d;
    sec_out     = sec_d;
    load        = commit_ok;
    entry_error = err_q || (in_commit && !range_ok);
    cur_field   = field_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      field_q <= FieldNone;
      state_q <= StIdle;
      cs_q    <= 1'b0;
      err_q   <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      field_q <= field_d;
      state_q <= state_d;
      cs_q    <= completeSetting;
      err_q   <= err_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

endmodule
